// File: rtl/rv_hazard_unit.sv
// Hazard unit for the 5-stage pipeline: EX forwarding selects, load-use / MUL-DIV stalls, branch flushes.
// Optional stall performance counter is enabled by defining HAZ_PERF_EN.
module rv_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_md_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic              ex_use_rs1_i,
  input  logic              ex_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_md_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              branch_taken_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic              flush_if_o,
  output logic              flush_id_o,
  output logic              md_busy_o,
  output logic              md_done_o,
  output logic [REG_AW-1:0] md_rd_o,
  output logic [PERF_W-1:0] perf_stall_cnt_o
);

  localparam int CNT_W = $clog2(MD_LAT + 1);
  localparam logic [REG_AW-1:0] REG_X0 = {REG_AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  md_state_e         state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [REG_AW-1:0] md_rd_r, md_rd_s;
  logic              load_use_s, md_ex_s, md_dep_s, haz_s;

  function automatic logic src_hit(input logic use_rs, input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] r);
    return use_rs && (rs != REG_X0) && (rs == r);
  endfunction

  // MEM result is younger than WB, so it takes priority
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_AW-1:0] rs,
                                         input logic mem_wr, input logic [REG_AW-1:0] mem_rd,
                                         input logic wb_wr, input logic [REG_AW-1:0] wb_rd);
    if (mem_wr && src_hit(use_rs, rs, mem_rd)) begin
      return 2'b10;
    end else if (wb_wr && src_hit(use_rs, rs, wb_rd)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  function automatic logic id_hit(input logic [REG_AW-1:0] r);
    return src_hit(id_use_rs1_i, id_rs1_i, r) || src_hit(id_use_rs2_i, id_rs2_i, r);
  endfunction

  // EX operand forwarding selects
  always_comb begin
    forward_a_o = fwd_sel(ex_use_rs1_i, ex_rs1_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
    forward_b_o = fwd_sel(ex_use_rs2_i, ex_rs2_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
  end

  // MUL/DIV scoreboard next state; an issue outside IDLE cannot happen and is ignored
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    md_rd_s = md_rd_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_md_i) begin
          state_s = ST_BUSY;
          cnt_s   = CNT_W'(MD_LAT - 1);
          md_rd_s = ex_rd_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Scoreboard registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      md_rd_r <= REG_X0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      md_rd_r <= md_rd_s;
    end
  end

  assign md_busy_o = (state_r != ST_IDLE);
  assign md_done_o = (state_r == ST_DONE);
  assign md_rd_o   = md_rd_r;

  // Stall/flush generation; a redirect squashes the stalled instruction anyway, so flush wins
  always_comb begin
    load_use_s = ex_mem_read_i && ex_reg_write_i && id_hit(ex_rd_i);
    md_ex_s    = ex_md_i && (id_hit(ex_rd_i) || id_md_i);
    md_dep_s   = md_busy_o && (id_hit(md_rd_r) ||
                 (id_reg_write_i && (id_rd_i == md_rd_r) && (md_rd_r != REG_X0)) || id_md_i);
    haz_s      = load_use_s || md_ex_s || md_dep_s;
    if (branch_taken_i) begin
      stall_o    = 1'b0;
      flush_if_o = 1'b1;
      flush_id_o = 1'b1;
    end else begin
      stall_o    = haz_s;
      flush_if_o = 1'b0;
      flush_id_o = haz_s;
    end
  end

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] perf_cnt_r;

  // Saturating stall cycle counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      perf_cnt_r <= {PERF_W{1'b0}};
    end else if (stall_o && (perf_cnt_r != {PERF_W{1'b1}})) begin
      perf_cnt_r <= perf_cnt_r + PERF_W'(1);
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_stall_cnt_o = perf_cnt_r;
`else
  assign perf_stall_cnt_o = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Self-checking bench for rv_hazard_unit: vector table for the combinational paths plus
// hand-written MUL/DIV scoreboard, redirect and reset sequences.
module tb_rv_hazard_unit;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i, ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_md_i;
  logic       ex_use_rs1_i, ex_use_rs2_i, ex_reg_write_i, ex_mem_read_i, ex_md_i;
  logic       mem_reg_write_i, wb_reg_write_i, branch_taken_i;
  logic [1:0] forward_a_o, forward_b_o;
  logic       stall_o, flush_if_o, flush_id_o, md_busy_o, md_done_o;
  logic [4:0] md_rd_o;
  logic [31:0] perf_stall_cnt_o;

  always #5 clk_i = ~clk_i;

  rv_hazard_unit dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_md_i(id_md_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .ex_use_rs1_i(ex_use_rs1_i), .ex_use_rs2_i(ex_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_md_i(ex_md_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_rd_i(mem_rd_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i),
    .branch_taken_i(branch_taken_i),
    .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .stall_o(stall_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .md_busy_o(md_busy_o), .md_done_o(md_done_o), .md_rd_o(md_rd_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
  );

  // exp = {fwd_a, fwd_b, stall, flush_if, flush_id, busy, done, md_rd}
  typedef struct {
    string      name;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_u1, id_u2, id_rw, id_md, ex_u1, ex_u2, ex_rw, ex_ld, ex_md, mem_rw, wb_rw, br;
    logic [13:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [13:0] exp;
  } sb_t;

  sb_t   sb_q[$];
  vec_t  tbl[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    perf_model = 0;

  function automatic logic [13:0] xp(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [4:0] flags, input logic [4:0] rd);
    return {fa, fb, flags, rd};
  endfunction

  function automatic vec_t nv(input string n);
    vec_t v;
    v.name = n; v.rst_n = 1'b1;
    v.id_rs1 = 5'd0; v.id_rs2 = 5'd0; v.id_rd = 5'd0; v.ex_rs1 = 5'd0; v.ex_rs2 = 5'd0;
    v.ex_rd = 5'd0; v.mem_rd = 5'd0; v.wb_rd = 5'd0;
    v.id_u1 = 1'b0; v.id_u2 = 1'b0; v.id_rw = 1'b0; v.id_md = 1'b0; v.ex_u1 = 1'b0;
    v.ex_u2 = 1'b0; v.ex_rw = 1'b0; v.ex_ld = 1'b0; v.ex_md = 1'b0; v.mem_rw = 1'b0;
    v.wb_rw = 1'b0; v.br = 1'b0;
    v.exp = 14'd0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t e;
    logic [13:0] act;
    @(negedge clk_i);
    rst_n_i = v.rst_n;
    id_rs1_i = v.id_rs1; id_rs2_i = v.id_rs2; id_rd_i = v.id_rd;
    id_use_rs1_i = v.id_u1; id_use_rs2_i = v.id_u2; id_reg_write_i = v.id_rw; id_md_i = v.id_md;
    ex_rs1_i = v.ex_rs1; ex_rs2_i = v.ex_rs2; ex_rd_i = v.ex_rd;
    ex_use_rs1_i = v.ex_u1; ex_use_rs2_i = v.ex_u2; ex_reg_write_i = v.ex_rw;
    ex_mem_read_i = v.ex_ld; ex_md_i = v.ex_md;
    mem_reg_write_i = v.mem_rw; mem_rd_i = v.mem_rd;
    wb_reg_write_i = v.wb_rw; wb_rd_i = v.wb_rd; branch_taken_i = v.br;
    e.name = v.name; e.exp = v.exp;
    sb_q.push_back(e);
    if (!v.rst_n) perf_model = 0;
    else if (v.exp[9]) perf_model++;
    #2;
    e = sb_q.pop_front();
    act = {forward_a_o, forward_b_o, stall_o, flush_if_o, flush_id_o, md_busy_o, md_done_o, md_rd_o};
    n_vec++;
    if (act !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
    end
  endtask

  // Valid right after a vector whose expected stall is 0
  task automatic check_perf(input string n);
    logic [31:0] exp_cnt;
`ifdef HAZ_PERF_EN
    exp_cnt = 32'(perf_model);
`else
    exp_cnt = 32'd0;
`endif
    n_vec++;
    if (perf_stall_cnt_o !== exp_cnt) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, perf_stall_cnt_o, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    v = nv("init");
    v.rst_n = 1'b0;
    rst_n_i = 1'b0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
    id_reg_write_i = 1'b0; id_md_i = 1'b0; ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; ex_rd_i = 5'd0;
    ex_use_rs1_i = 1'b0; ex_use_rs2_i = 1'b0; ex_reg_write_i = 1'b0; ex_mem_read_i = 1'b0;
    ex_md_i = 1'b0; mem_reg_write_i = 1'b0; mem_rd_i = 5'd0; wb_reg_write_i = 1'b0;
    wb_rd_i = 5'd0; branch_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // ---- combinational vector table (scoreboard idle, md_rd = 0) ----
    v = nv("reset_state"); v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v = nv("fwd_a_mem"); v.mem_rw = 1'b1; v.mem_rd = 5'd5; v.wb_rw = 1'b1; v.wb_rd = 5'd5;
    v.ex_rs1 = 5'd5; v.ex_u1 = 1'b1; v.exp = xp(2'b10, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "fwd_a_wb"; v.mem_rd = 5'd0; v.exp = xp(2'b01, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "fwd_a_none"; v.wb_rd = 5'd0; v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "fwd_a_x0"; v.ex_rs1 = 5'd0; tbl.push_back(v);
    v = nv("fwd_a_nouse"); v.mem_rw = 1'b1; v.mem_rd = 5'd5; v.ex_rs1 = 5'd5;
    v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v = nv("fwd_b_wb"); v.wb_rw = 1'b1; v.wb_rd = 5'd7; v.ex_rs2 = 5'd7; v.ex_u2 = 1'b1;
    v.exp = xp(2'b00, 2'b01, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "fwd_b_nouse"; v.ex_u2 = 1'b0; v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "fwd_b_nowr"; v.ex_u2 = 1'b1; v.wb_rw = 1'b0; tbl.push_back(v);
    v = nv("fwd_b_mem"); v.mem_rw = 1'b1; v.mem_rd = 5'd6; v.wb_rw = 1'b1; v.wb_rd = 5'd6;
    v.ex_rs2 = 5'd6; v.ex_u2 = 1'b1; v.exp = xp(2'b00, 2'b10, 5'b00000, 5'd0); tbl.push_back(v);
    v = nv("fwd_split"); v.mem_rw = 1'b1; v.mem_rd = 5'd4; v.wb_rw = 1'b1; v.wb_rd = 5'd8;
    v.ex_rs1 = 5'd8; v.ex_u1 = 1'b1; v.ex_rs2 = 5'd4; v.ex_u2 = 1'b1;
    v.exp = xp(2'b01, 2'b10, 5'b00000, 5'd0); tbl.push_back(v);
    v = nv("lu_rs1"); v.ex_ld = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd3; v.id_rs1 = 5'd3; v.id_u1 = 1'b1;
    v.exp = xp(2'b00, 2'b00, 5'b10100, 5'd0); tbl.push_back(v);
    v.name = "lu_branch"; v.br = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b01100, 5'd0); tbl.push_back(v);
    v.name = "lu_nouse"; v.br = 1'b0; v.id_u1 = 1'b0; v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    v.name = "lu_nowr"; v.id_u1 = 1'b1; v.ex_rw = 1'b0; tbl.push_back(v);
    v.name = "lu_rs1_zero"; v.ex_rw = 1'b1; v.id_rs1 = 5'd0; tbl.push_back(v);
    v.name = "lu_x0"; v.ex_rd = 5'd0; tbl.push_back(v);
    v = nv("lu_rs2"); v.ex_ld = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd3; v.id_rs2 = 5'd3; v.id_u2 = 1'b1;
    v.exp = xp(2'b00, 2'b00, 5'b10100, 5'd0); tbl.push_back(v);
    v = nv("branch_only"); v.br = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b01100, 5'd0); tbl.push_back(v);
    v = nv("idle"); v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); tbl.push_back(v);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ---- MUL/DIV RAW: issue rd=9 at c0, ID reads x9 throughout ----
    v = nv("md_c0"); v.ex_md = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd9; v.id_rs1 = 5'd9; v.id_u1 = 1'b1;
    v.exp = xp(2'b00, 2'b00, 5'b10100, 5'd0); apply(v);
    v = nv("md_busy"); v.id_rs1 = 5'd9; v.id_u1 = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b10110, 5'd9);
    for (int c = 1; c <= 4; c++) apply(v);
    v.name = "md_done"; v.exp = xp(2'b00, 2'b00, 5'b10111, 5'd9); apply(v);
    v.name = "md_retired"; v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd9); apply(v);
    check_perf("perf_after_md");

    // ---- WAW / MD-after-MD / redirect / reset mid-BUSY ----
    v = nv("b0_issue"); v.ex_md = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd12;
    v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd9); apply(v);
    v = nv("b1_waw"); v.id_rw = 1'b1; v.id_rd = 5'd12; v.exp = xp(2'b00, 2'b00, 5'b10110, 5'd12); apply(v);
    v.name = "b2_nodep"; v.id_rd = 5'd13; v.exp = xp(2'b00, 2'b00, 5'b00010, 5'd12); apply(v);
    v = nv("b3_md_md"); v.id_md = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b10110, 5'd12); apply(v);
    v = nv("b4_busy"); v.exp = xp(2'b00, 2'b00, 5'b00010, 5'd12); apply(v);
    v.name = "b5_done"; v.exp = xp(2'b00, 2'b00, 5'b00011, 5'd12); apply(v);
    v = nv("b6_md_ex"); v.ex_md = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd2; v.id_md = 1'b1;
    v.exp = xp(2'b00, 2'b00, 5'b10100, 5'd12); apply(v);
    v = nv("b7_redirect"); v.br = 1'b1; v.id_md = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b01110, 5'd2); apply(v);
    v = nv("b8_rst"); v.rst_n = 1'b0; v.exp = xp(2'b00, 2'b00, 5'b00010, 5'd2); apply(v);
    v = nv("b9_after_rst"); v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); apply(v);
    check_perf("perf_after_rst");
    v = nv("b10_issue_x0"); v.ex_md = 1'b1; v.ex_rw = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b00000, 5'd0); apply(v);
    v = nv("b11_x0_nodep"); v.id_rw = 1'b1; v.id_u1 = 1'b1; v.exp = xp(2'b00, 2'b00, 5'b00010, 5'd0); apply(v);
    v = nv("b12_lu_busy"); v.ex_ld = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd3; v.id_rs1 = 5'd3; v.id_u1 = 1'b1;
    v.exp = xp(2'b00, 2'b00, 5'b10110, 5'd0); apply(v);
    v = nv("b13_busy"); v.exp = xp(2'b00, 2'b00, 5'b00010, 5'd0); apply(v);
    check_perf("perf_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
